// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and receiver states.
// Meant to be reused by the future uart_tx.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial line and received-byte outputs of the UART receiver.
// The master modport is the receiver's view; the slave modport is the consumer's view.
interface uart_rx_core_if;
    import uart_pkg::*;

    logic                      rx_i;
    logic [UART_DATA_BITS-1:0] data_o;
    logic                      valid_o;
    logic                      frame_err_o;
    logic                      busy_o;

    modport master (
        input  rx_i,
        output data_o,
        output valid_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        output rx_i,
        input  data_o,
        input  valid_o,
        input  frame_err_o,
        input  busy_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines do not glitch on reset release.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error detection.
// A stop bit sampled low parks the FSM in StBreak until the line returns high.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    uart_rx_core_if.master  bus
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    logic w_rx_s;

    uart_state_e          r_state, w_state_d;
    logic [CntW-1:0]      r_cnt, w_cnt_d;
    logic [IdxW-1:0]      r_idx, w_idx_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic [DATA_BITS-1:0] r_data, w_data_d;
    logic                 r_valid, w_valid_d;
    logic                 r_frame_err, w_frame_err_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .d_i    (bus.rx_i),
        .q_o    (w_rx_s)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_idx       <= w_idx_d;
            r_shift     <= w_shift_d;
            r_data      <= w_data_d;
            r_valid     <= w_valid_d;
            r_frame_err <= w_frame_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt + 1'b1;
        w_idx_d       = r_idx;
        w_shift_d     = r_shift;
        w_data_d      = r_data;
        w_valid_d     = 1'b0;
        w_frame_err_d = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (!w_rx_s) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (r_cnt == CntHalf) begin
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                    w_state_d = w_rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (r_cnt == CntLast) begin
                    w_cnt_d   = '0;
                    w_shift_d = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_idx_d   = r_idx + 1'b1;
                    if (r_idx == IdxLast) begin
                        w_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (r_cnt == CntLast) begin
                    w_cnt_d = '0;
                    if (w_rx_s) begin
                        w_data_d  = r_shift;
                        w_valid_d = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                if (w_rx_s) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    assign bus.data_o      = r_data;
    assign bus.valid_o     = r_valid;
    assign bus.frame_err_o = r_frame_err;
    assign bus.busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit: reset, framing, glitch,
// framing error, jittered back-to-back frames and reset mid-frame.
module tb_uart_rx_core;

    localparam int unsigned Cpb   = 16;
    localparam int          BitNs = 160;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_rx_core_if u_if ();

    uart_rx_core #(
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (u_if)
    );

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int last_lat  = -1;
    int n_valid   = 0;
    int n_ferr    = 0;
    int n_start   = 0;
    int n_both    = 0;
    logic busy_prev = 1'b0;
    logic [7:0] data_q[$];

    always @(negedge clk) begin
        cyc++;
        if (u_if.busy_o === 1'b1 && busy_prev !== 1'b1) begin
            start_cyc = cyc;
            n_start++;
        end
        if (u_if.valid_o === 1'b1) begin
            n_valid++;
            last_lat = cyc - start_cyc;
            data_q.push_back(u_if.data_o);
        end
        if (u_if.frame_err_o === 1'b1) n_ferr++;
        if (u_if.valid_o === 1'b1 && u_if.frame_err_o === 1'b1) n_both++;
        busy_prev = u_if.busy_o;
    end

    task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop);
        u_if.rx_i = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            u_if.rx_i = b[i];
            #(bit_ns);
        end
        u_if.rx_i = stop;
        #(bit_ns);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        u_if.rx_i = 1'b1;
        #23;
        checks++;
        if (u_if.data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", u_if.data_o);
        end
        checks++;
        if ({u_if.valid_o, u_if.frame_err_o, u_if.busy_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000",
                     {u_if.valid_o, u_if.frame_err_o, u_if.busy_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (n_valid + n_ferr + n_start !== 0) begin
            failures++;
            $display("FAIL idle_after_reset valid=%0d ferr=%0d starts=%0d exp=0,0,0",
                     n_valid, n_ferr, n_start);
        end
    endtask

    task automatic test_single_frame();
        int v0 = n_valid;
        int f0 = n_ferr;
        send_byte(8'hA5, BitNs, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 1) begin
            failures++;
            $display("FAIL single_valid_count got=%0d exp=1", n_valid - v0);
        end
        checks++;
        if (u_if.data_o !== 8'hA5) begin
            failures++;
            $display("FAIL single_data got=%h exp=a5", u_if.data_o);
        end
        checks++;
        if (last_lat !== 152) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=152", last_lat);
        end
        checks++;
        if (n_ferr !== f0 || u_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_ferr_busy ferr=%0d busy=%b exp=%0d,0",
                     n_ferr - f0, u_if.busy_o, 0);
        end
    endtask

    task automatic test_glitch();
        int v0 = n_valid;
        int f0 = n_ferr;
        int s0 = n_start;
        @(negedge clk);
        u_if.rx_i = 1'b0;
        #40;
        u_if.rx_i = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (n_start - s0 !== 1) begin
            failures++;
            $display("FAIL glitch_start got=%0d exp=1", n_start - s0);
        end
        checks++;
        if (n_valid !== v0 || n_ferr !== f0) begin
            failures++;
            $display("FAIL glitch_strobes valid=%0d ferr=%0d exp=0,0", n_valid - v0, n_ferr - f0);
        end
        checks++;
        if (u_if.data_o !== 8'hA5 || u_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL glitch_data_busy data=%h busy=%b exp=a5,0", u_if.data_o, u_if.busy_o);
        end
    endtask

    task automatic test_framing_error();
        int v0 = n_valid;
        int f0 = n_ferr;
        int busy_low = 0;
        send_byte(8'h3C, BitNs, 1'b0);
        repeat (48) begin
            @(negedge clk);
            if (u_if.busy_o !== 1'b1) busy_low++;
        end
        checks++;
        if (busy_low !== 0) begin
            failures++;
            $display("FAIL break_busy low_cycles=%0d exp=0", busy_low);
        end
        checks++;
        if (n_ferr - f0 !== 1 || n_valid !== v0) begin
            failures++;
            $display("FAIL ferr_strobes ferr=%0d valid=%0d exp=1,0", n_ferr - f0, n_valid - v0);
        end
        checks++;
        if (u_if.data_o !== 8'hA5) begin
            failures++;
            $display("FAIL ferr_data got=%h exp=a5", u_if.data_o);
        end
        u_if.rx_i = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (u_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL break_exit busy=%b exp=0", u_if.busy_o);
        end
        v0 = n_valid;
        send_byte(8'h5A, BitNs, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 1 || u_if.data_o !== 8'h5A) begin
            failures++;
            $display("FAIL recover_frame count=%0d data=%h exp=1,5a", n_valid - v0, u_if.data_o);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid;
        logic [7:0] got0;
        logic [7:0] got1;
        data_q.delete();
        @(negedge clk);
        send_byte(8'h00, 165, 1'b1);
        send_byte(8'hFF, 155, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", n_valid - v0);
        end
        got0 = (data_q.size() > 0) ? data_q[0] : 8'hxx;
        got1 = (data_q.size() > 1) ? data_q[1] : 8'hxx;
        checks++;
        if (got0 !== 8'h00) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=00", got0);
        end
        checks++;
        if (got1 !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=ff", got1);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'h81;
        int v0 = n_valid;
        int f0 = n_ferr;
        @(negedge clk);
        u_if.rx_i = 1'b0;
        #(BitNs);
        for (int i = 0; i < 4; i++) begin
            u_if.rx_i = b[i];
            #(BitNs);
        end
        u_if.rx_i = b[4];
        #(BitNs / 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_if.data_o !== 8'h00 || u_if.busy_o !== 1'b0 || u_if.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs data=%h busy=%b valid=%b exp=00,0,0",
                     u_if.data_o, u_if.busy_o, u_if.valid_o);
        end
        u_if.rx_i = 1'b1;
        #40;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (n_valid !== v0 || n_ferr !== f0 || u_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_strobe valid=%0d ferr=%0d busy=%b exp=0,0,0",
                     n_valid - v0, n_ferr - f0, u_if.busy_o);
        end
        send_byte(8'h81, BitNs, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 1 || u_if.data_o !== 8'h81) begin
            failures++;
            $display("FAIL midreset_resend count=%0d data=%h exp=1,81", n_valid - v0, u_if.data_o);
        end
    endtask

    initial begin
        u_if.rx_i = 1'b1;
        test_reset();
        test_single_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL strobe_overlap cycles=%0d exp=0", n_both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
